// File: rtl/mat3_pkg.sv
// Shared types and constants for the 3x3 matrix operand loader and result readout.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   state_t     loader phase: LOAD -> FLUSH -> RUN -> DONE
//   MAT_WORDS   words per 3x3 matrix
//   OP_WORDS    words per job (matrix A followed by matrix B)
//   WORD_BYTES  byte stride between consecutive words in data memory
//   CNT_W       width of the accepted-word counter (holds 0..OP_WORDS)
package mat3_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MAT_WORDS  = 9;
    localparam int OP_WORDS   = 18;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 5;

    // Word position inside its own matrix: A words are 0..8, B words restart at 0.
    function automatic logic [CNT_W-1:0] mat_index(input logic [CNT_W-1:0] k);
        if (k >= CNT_W'(MAT_WORDS)) begin
            return k - CNT_W'(MAT_WORDS);
        end
        return k;
    endfunction

endpackage

// File: rtl/mat3_addr_gen.sv
// Maps the running operand index to its data-memory byte address (A block, then B block).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of i_cnt.
//
// Ports:
//   i_cnt   in   CNT_W   operand index k (0..17)
//   o_addr  out  DATA_W  byte address: A_BASE + 4*k for k<9, B_BASE + 4*(k-9) otherwise
module mat3_addr_gen
    import mat3_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int A_BASE = 0,
    parameter int B_BASE = 36
) (
    input  logic [CNT_W-1:0]  i_cnt,
    output logic [DATA_W-1:0] o_addr
);

    logic              w_is_b;
    logic [CNT_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_base;

    assign w_is_b = (i_cnt >= CNT_W'(MAT_WORDS));
    assign w_idx  = mat_index(i_cnt);
    assign w_base = w_is_b ? DATA_W'(B_BASE) : DATA_W'(A_BASE);
    assign o_addr = w_base + (DATA_W'(w_idx) * DATA_W'(WORD_BYTES));

endmodule

// File: rtl/mat3_operand_loader.sv
// Streams 18 operand words (A then B, row-major) into core data memory, then sweeps the core pc.
// Latency: accepted word appears on mem_we/mem_addr/mem_wdata one cycle later; pc steps once per cycle in RUN.
// Backpressure: s_ready is high only in LOAD with no restart; the source holds its word otherwise.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   restart       synchronous abort back to LOAD, clears word count and pc
//   s_valid/s_ready/s_data   operand word stream
//   mem_we/mem_addr/mem_wdata   registered data-memory write port, one strobe per word
//   pc            registered program counter driven to the core
//   run, done     decoded phase flags (pc advancing / sweep finished)
module mat3_operand_loader
    import mat3_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int A_BASE  = 0,
    parameter int B_BASE  = 36,
    parameter int PC_LAST = 996
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] pc,
    output logic              run,
    output logic              done
);

    // The pc steps by a whole word, so a final pc off the word grid would never be hit.
    if ((PC_LAST % WORD_BYTES) != 0 || PC_LAST < 0) begin : g_bad_pc_last
        $error("mat3_operand_loader: PC_LAST must be a non-negative multiple of 4");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_pc;

    logic              w_accept;
    logic              w_last_word;
    logic              w_pc_at_last;
    logic [DATA_W-1:0] w_addr;

    assign w_accept     = s_valid && s_ready;
    assign w_last_word  = (r_cnt == CNT_W'(OP_WORDS - 1));
    assign w_pc_at_last = (r_pc == DATA_W'(PC_LAST));

    mat3_addr_gen #(
        .DATA_W (DATA_W),
        .A_BASE (A_BASE),
        .B_BASE (B_BASE)
    ) u_addr_gen (
        .i_cnt  (r_cnt),
        .o_addr (w_addr)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic; restart overrides every transition
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = LOAD;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept && w_last_word) begin
                        w_state_nxt = FLUSH;
                    end
                end
                // One idle cycle so the final write lands before the core starts fetching.
                FLUSH: w_state_nxt = RUN;
                RUN: begin
                    if (w_pc_at_last) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = LOAD;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM: decoded outputs
    // ---------------------------------------------------------------
    always_comb begin
        s_ready = 1'b0;
        run     = 1'b0;
        done    = 1'b0;
        case (r_state)
            // restart gates ready so a same-cycle word is left with the source.
            LOAD:    s_ready = !restart;
            RUN:     run     = 1'b1;
            DONE:    done    = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Word counter: saturates at OP_WORDS, only reset/restart clear it
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt < CNT_W'(OP_WORDS))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Memory write port: one strobe per accepted word. Address/data
    // hold their last value while the strobe is low.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_accept;
            if (w_accept) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= s_data;
            end
        end
    end

    // ---------------------------------------------------------------
    // Program counter: 0 outside RUN/DONE, steps a word per RUN cycle
    // and parks on PC_LAST.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (restart) begin
            r_pc <= '0;
        end else if ((r_state == RUN) && !w_pc_at_last) begin
            r_pc <= r_pc + DATA_W'(WORD_BYTES);
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign pc        = r_pc;

endmodule

// File: tb/tb_mat3_operand_loader.sv
module tb_mat3_operand_loader;

    localparam int PC_LAST = 996;
    localparam int RUN_CYC = PC_LAST / 4 + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] pc;
    logic        run;
    logic        done;

    always #5 clk = ~clk;

    mat3_operand_loader #(
        .DATA_W  (32),
        .A_BASE  (0),
        .B_BASE  (36),
        .PC_LAST (PC_LAST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .pc        (pc),
        .run       (run),
        .done      (done)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] tb_mem [0:63];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference model, evaluated on every falling edge. It tracks how many
    // words the spec says have been taken and the cycle count since the
    // 18th accept, and derives every expected output from those two numbers.
    task automatic monitor_loop();
        int          m_k    = 0;
        int          m_t    = -1;
        bit          m_pacc = 1'b0;
        logic [31:0] m_paddr = '0;
        logic [31:0] m_pdata = '0;
        bit          exp_rdy;
        logic [31:0] exp_pc;
        bit          exp_run;
        bit          exp_done;
        forever begin
            @(negedge clk);
            if (mem_we && mem_addr < 32'd256) tb_mem[mem_addr[7:2]] = mem_wdata;
            if (!mon_en) begin
                m_k    = 0;
                m_t    = -1;
                m_pacc = 1'b0;
            end else begin
                exp_rdy  = (m_k < 18) && !restart;
                exp_run  = 1'b0;
                exp_done = 1'b0;
                exp_pc   = 32'd0;
                if (m_t >= 1 && m_t <= RUN_CYC) begin
                    exp_run = 1'b1;
                    exp_pc  = 32'(4 * (m_t - 1));
                end else if (m_t > RUN_CYC) begin
                    exp_done = 1'b1;
                    exp_pc   = 32'(PC_LAST);
                end
                check_eq("s_ready", 32'(s_ready), 32'(exp_rdy));
                check_eq("run", 32'(run), 32'(exp_run));
                check_eq("done", 32'(done), 32'(exp_done));
                check_eq("pc", pc, exp_pc);
                check_eq("mem_we", 32'(mem_we), 32'(m_pacc));
                if (m_pacc) begin
                    check_eq("mem_addr", mem_addr, m_paddr);
                    check_eq("mem_wdata", mem_wdata, m_pdata);
                end
                if (restart) begin
                    m_k    = 0;
                    m_t    = -1;
                    m_pacc = 1'b0;
                end else begin
                    m_pacc = s_valid && exp_rdy;
                    if (m_pacc) begin
                        m_paddr = (m_k < 9) ? 32'(4 * m_k) : 32'(36 + 4 * (m_k - 9));
                        m_pdata = s_data;
                        m_k++;
                    end
                    if (m_pacc && m_k == 18) m_t = 0;
                    else if (m_t >= 0 && m_t < 2000) m_t++;
                end
            end
        end
    endtask

    task automatic load_words(input logic [31:0] w [18], input int n, input bit gaps);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 1000) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = s_valid ? w[k] : $urandom;
            @(negedge clk);
            if (s_valid && s_ready) k++;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        if (k < n) check_eq("load_timeout", 32'(k), 32'(n));
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < RUN_CYC + 50) begin
            @(negedge clk);
            c++;
        end
        check_eq("done_reached", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("pc_held", pc, 32'(PC_LAST));
        @(posedge clk);
        #1;
    endtask

    // Product of the matrices as they sit in the bench's copy of memory,
    // compared against the product of the words the source sent.
    task automatic check_product(input logic [31:0] w [18], input string nm);
        logic [31:0] got;
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                got = '0;
                exp = '0;
                for (int k = 0; k < 3; k++) begin
                    got += tb_mem[i * 3 + k] * tb_mem[9 + k * 3 + j];
                    exp += w[i * 3 + k] * w[9 + k * 3 + j];
                end
                check_eq($sformatf("%s_d%0d%0d", nm, i + 1, j + 1), got, exp);
            end
        end
    endtask

    task automatic pulse_restart(input bit with_valid);
        restart = 1'b1;
        s_valid = with_valid;
        s_data  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        restart = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    function automatic void rand_job(output logic [31:0] w [18]);
        for (int i = 0; i < 18; i++) w[i] = 32'($urandom_range(1, 200));
    endfunction

    initial begin
        logic [31:0] job [18];
        logic [31:0] ref_c [9];
        int          c;

        for (int i = 0; i < 64; i++) tb_mem[i] = '0;
        rst_n   = 1'b0;
        restart = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_pc", pc, 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_run", 32'(run), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Job 1: A = 1..9, B = 9..1, continuous stream
        for (int i = 0; i < 9; i++) begin
            job[i]     = 32'(i + 1);
            job[i + 9] = 32'(9 - i);
        end
        load_words(job, 18, 1'b0);
        wait_done();
        ref_c = '{32'd30, 32'd24, 32'd18, 32'd84, 32'd69, 32'd54, 32'd138, 32'd114, 32'd90};
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("job1_const_%0d", i),
                     tb_mem[(i / 3) * 3 + 0] * tb_mem[9 + i % 3]
                   + tb_mem[(i / 3) * 3 + 1] * tb_mem[12 + i % 3]
                   + tb_mem[(i / 3) * 3 + 2] * tb_mem[15 + i % 3], ref_c[i]);
        end

        // Restart from DONE, then a second job with gaps in the stream
        pulse_restart(1'b0);
        @(negedge clk);
        check_eq("restart_done_pc", pc, 32'd0);
        check_eq("restart_done_done", 32'(done), 32'd0);
        check_eq("restart_done_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        rand_job(job);
        load_words(job, 18, 1'b1);
        wait_done();
        check_product(job, "job2");

        // Restart mid-load with a word on offer: the word must not be taken
        pulse_restart(1'b0);
        rand_job(job);
        load_words(job, 5, 1'b1);
        pulse_restart(1'b1);
        @(negedge clk);
        check_eq("restart_no_write", 32'(mem_we), 32'd0);
        @(negedge clk);
        check_eq("restart_word_absent", 32'(tb_mem[5] == 32'hDEADBEEF), 32'd0);
        @(posedge clk);
        #1;
        rand_job(job);
        load_words(job, 18, 1'b1);
        wait_done();
        check_product(job, "job3");

        // Asynchronous reset in the middle of RUN
        pulse_restart(1'b0);
        rand_job(job);
        load_words(job, 18, 1'b1);
        c = 0;
        while (!run && c < 20) begin
            @(posedge clk);
            c++;
        end
        check_eq("run_started", 32'(run), 32'd1);
        repeat (100) @(posedge clk);
        #1;
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_pc", pc, 32'd0);
        check_eq("arst_run", 32'(run), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_mem_we", 32'(mem_we), 32'd0);
        check_eq("arst_mem_addr", mem_addr, 32'd0);
        check_eq("arst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_ready_after", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Recovery job after the reset
        rand_job(job);
        load_words(job, 18, 1'b1);
        wait_done();
        check_product(job, "job5");

        mon_en = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
